// File: rtl/pll_lock_reset_sequencer_if.sv
// Signal bundle between the PLL lock/reset sequencer and its surroundings.
// The sequencer takes the master modport; the PLL wrapper side takes the slave modport.
interface pll_lock_reset_sequencer_if #(
    parameter int unsigned CNT_W = 8
) ();
    logic             locked;
    logic             force_pll_rst;
    logic             pll_rst;
    logic             sys_rst;
    logic             ready;
    logic             lock_lost;
    logic [CNT_W-1:0] loss_count;
    logic [CNT_W-1:0] retry_count;
    logic [2:0]       state;

    modport master (
        input  locked,
        input  force_pll_rst,
        output pll_rst,
        output sys_rst,
        output ready,
        output lock_lost,
        output loss_count,
        output retry_count,
        output state
    );

    modport slave (
        output locked,
        output force_pll_rst,
        input  pll_rst,
        input  sys_rst,
        input  ready,
        input  lock_lost,
        input  loss_count,
        input  retry_count,
        input  state
    );
endinterface

// File: rtl/pll_lock_reset_sequencer.sv
// PLL lock qualifier and system reset sequencer.
// Synchronises the asynchronous PLL LOCK into the board clock domain, requires it to be
// stable before releasing sys_rst, pulses the PLL reset on lock timeout or on request,
// and keeps saturating counts of lock losses and PLL reset retries.
module pll_lock_reset_sequencer #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned HOLD_CYCLES   = 256,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned PLLRST_CYCLES = 16,
    parameter int unsigned CNT_W         = 8
) (
    input logic                        clock,
    input logic                        resetn,
    pll_lock_reset_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        StWaitLock = 3'd0,
        StStable   = 3'd1,
        StHold     = 3'd2,
        StRun      = 3'd3,
        StPllReset = 3'd4
    } state_e;

    // One shared timer, sized for the longest dwell it ever has to count.
    localparam int unsigned MAX_SH    = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES
                                                                      : HOLD_CYCLES;
    localparam int unsigned MAX_TP    = (LOCK_TIMEOUT > PLLRST_CYCLES) ? LOCK_TIMEOUT
                                                                       : PLLRST_CYCLES;
    localparam int unsigned TIMER_MAX = (MAX_SH > MAX_TP) ? MAX_SH : MAX_TP;
    localparam int unsigned TIMER_W   = $clog2(TIMER_MAX);

    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] HOLD_LAST    = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] PLLRST_LAST  = TIMER_W'(PLLRST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_SAT      = {CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_e                 state_q, state_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic [CNT_W-1:0]       loss_q, loss_d;
    logic [CNT_W-1:0]       retry_q, retry_d;
    logic                   sys_rst_q, sys_rst_d;
    logic                   ready_q, ready_d;
    logic                   pll_rst_q, pll_rst_d;
    logic                   lock_lost_q, lock_lost_d;
    logic                   locked_s;
    logic                   lock_loss;

    // Raw LOCK feeds flop 1 directly; nothing combinational in front of the synchroniser.
    assign sync_d   = {sync_q[SYNC_STAGES-2:0], bus.locked};
    assign locked_s = sync_q[SYNC_STAGES-1];

    // Next-state, timer, counters and next-state-decoded outputs.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + TIMER_W'(1);
        lock_loss = 1'b0;

        unique case (state_q)
            StWaitLock: begin
                if (locked_s) begin
                    state_d = StStable;
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d = StPllReset;
                end
            end
            StStable: begin
                if (!locked_s) begin
                    state_d = StWaitLock;
                end else if (timer_q == STABLE_LAST) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (!locked_s) begin
                    state_d = StWaitLock;
                end else if (timer_q == HOLD_LAST) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                timer_d = timer_q;
                if (!locked_s) begin
                    state_d   = StWaitLock;
                    lock_loss = 1'b1;
                end
            end
            StPllReset: begin
                if (timer_q == PLLRST_LAST) begin
                    state_d = StWaitLock;
                end
            end
            default: begin
                state_d = StWaitLock;
            end
        endcase

        // Forced PLL reset overrides everything; inside PLL_RESET it stretches the pulse.
        if (bus.force_pll_rst) begin
            state_d = StPllReset;
        end

        if ((state_d != state_q) || (bus.force_pll_rst && (state_q == StPllReset))) begin
            timer_d = '0;
        end

        loss_d = loss_q;
        if (lock_loss && (loss_q != CNT_SAT)) begin
            loss_d = loss_q + CNT_W'(1);
        end

        retry_d = retry_q;
        if ((state_d == StPllReset) && (state_q != StPllReset) && (retry_q != CNT_SAT)) begin
            retry_d = retry_q + CNT_W'(1);
        end

        sys_rst_d   = (state_d != StRun);
        ready_d     = (state_d == StRun);
        pll_rst_d   = (state_d == StPllReset);
        lock_lost_d = lock_loss;
    end

    // State, synchroniser, counters and registered outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_q      <= '0;
            state_q     <= StWaitLock;
            timer_q     <= '0;
            loss_q      <= '0;
            retry_q     <= '0;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            pll_rst_q   <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
            loss_q      <= loss_d;
            retry_q     <= retry_d;
            sys_rst_q   <= sys_rst_d;
            ready_q     <= ready_d;
            pll_rst_q   <= pll_rst_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign bus.pll_rst     = pll_rst_q;
    assign bus.sys_rst     = sys_rst_q;
    assign bus.ready       = ready_q;
    assign bus.lock_lost   = lock_lost_q;
    assign bus.loss_count  = loss_q;
    assign bus.retry_count = retry_q;
    assign bus.state       = state_q;

endmodule
